// File: rtl/pipe_add_atr.sv
// pipe_add_atr: chunked carry-pipelined add/sub/inc/pass with valid/ready stall; PIPE_ADD_SAT_EN adds unsigned saturation
module pipe_add_atr #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co
`ifdef PIPE_ADD_SAT_EN
    ,
    output logic             out_sat
`endif
);
    localparam int CW = WIDTH / STAGES;
    localparam logic [1:0] M_ADD  = 2'b00;
    localparam logic [1:0] M_SUB  = 2'b01;
    localparam logic [1:0] M_PASS = 2'b11;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_add_atr: WIDTH must be a positive multiple of STAGES");
    end

    logic                           stall;
    logic [STAGES-1:0]              v_q, v_d, c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
    logic [STAGES-1:0][1:0]         m_q, m_d;
`ifdef PIPE_ADD_SAT_EN
    logic                           sat_q, sat_d;
    assign out_sat = sat_q;
`endif

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_co    = c_q[STAGES-1];

    // per stage: add one chunk with the carry registered by the previous stage, skew the rest along
    always_comb begin
        logic [WIDTH-1:0] pa, pb, ps;
        logic [1:0]       pm;
        logic [CW:0]      t;
        logic             pc, pv, co;
        int               j;
        v_d = v_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        m_d = m_q;
`ifdef PIPE_ADD_SAT_EN
        sat_d = sat_q;
`endif
        pa = '0;
        pb = '0;
        ps = '0;
        pm = '0;
        pc = 1'b0;
        pv = 1'b0;
        co = 1'b0;
        t  = '0;
        j  = 0;
        for (int k = 0; k < STAGES; k++) begin
            j  = (k > 0) ? k - 1 : 0;
            pa = (k == 0) ? in_a : a_q[j];
            pb = (k > 0) ? b_q[j] : (in_mode == M_ADD) ? in_b : (in_mode == M_SUB) ? ~in_b : '0;
            pc = (k > 0) ? c_q[j] : (in_mode == M_ADD) ? in_ci : (in_mode != M_PASS);
            pm = (k == 0) ? in_mode : m_q[j];
            pv = (k == 0) ? in_valid : v_q[j];
            ps = (k == 0) ? '0 : s_q[j];
            t  = {1'b0, pa[k*CW +: CW]} + {1'b0, pb[k*CW +: CW]} + {{CW{1'b0}}, pc};
            ps[k*CW +: CW] = t[CW-1:0];
            co = t[CW];
            if (!stall) begin
                v_d[k] = pv;
                a_d[k] = pa;
                b_d[k] = pb;
                m_d[k] = pm;
                s_d[k] = ps;
                c_d[k] = co;
            end
        end
        if (!stall) begin
            c_d[STAGES-1] = co & (pm != M_PASS);
`ifdef PIPE_ADD_SAT_EN
            sat_d = (pm == M_SUB) ? ~co : (pm != M_PASS) & co;
            s_d[STAGES-1] = !sat_d ? ps : (pm == M_SUB) ? '0 : '1;
`endif
        end
    end

    // stage registers; reset clears valids and the visible result
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            m_q <= '0;
`ifdef PIPE_ADD_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            m_q <= m_d;
`ifdef PIPE_ADD_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end
endmodule

// File: tb/tb_pipe_add_atr.sv
// tb_pipe_add_atr: directed and random checks of pipe_add_atr against an arithmetic reference model
module tb_pipe_add_atr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ci = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [1:0]  in_mode = '0;
    logic        in_ready, out_valid, out_co;
    logic [7:0]  out_sum;
    logic        in_ready1, out_valid1, out_co1;
    logic [7:0]  out_sum1;
    logic        v16 = 1'b0;
    logic        ci16 = 1'b0;
    logic [1:0]  m16 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        in_ready16, out_valid16, out_co16;
    logic [15:0] sum16;
`ifdef PIPE_ADD_SAT_EN
    logic        sat8, sat1, sat16;
`endif

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       sat;
        logic       co;
        logic [7:0] sum;
    } res_t;

    res_t exp_q[$];

    always #5 clk = ~clk;

    pipe_add_atr #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co)
`ifdef PIPE_ADD_SAT_EN
        , .out_sat(sat8)
`endif
    );

    pipe_add_atr #(.WIDTH(8), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_mode(in_mode),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1), .out_co(out_co1)
`ifdef PIPE_ADD_SAT_EN
        , .out_sat(sat1)
`endif
    );

    pipe_add_atr #(.WIDTH(16), .STAGES(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(in_ready16),
        .in_a(a16), .in_b(b16), .in_ci(ci16), .in_mode(m16),
        .out_valid(out_valid16), .out_ready(out_ready), .out_sum(sum16), .out_co(out_co16)
`ifdef PIPE_ADD_SAT_EN
        , .out_sat(sat16)
`endif
    );

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [1:0] m);
        res_t r;
        int   s;
        s = (m == 2'd0) ? int'(a) + int'(b) + int'(ci) :
            (m == 2'd1) ? int'(a) - int'(b) + 256 :
            (m == 2'd2) ? int'(a) + 1 : int'(a);
        r.sum = 8'(s % 256);
        r.co  = (m == 2'd1) ? (a >= b) : (m == 2'd3) ? 1'b0 : (s > 255);
        r.sat = 1'b0;
`ifdef PIPE_ADD_SAT_EN
        r.sat = (m == 2'd3) ? 1'b0 : (m == 2'd1) ? !r.co : r.co;
        if (r.sat) r.sum = (m == 2'd1) ? 8'h00 : 8'hFF;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] sum, input logic co, input logic sat, input res_t e);
        chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
        chk({tag, "_co"}, 32'(co), 32'(e.co));
`ifdef PIPE_ADD_SAT_EN
        chk({tag, "_sat"}, 32'(sat), 32'(e.sat));
`else
        if (sat !== 1'b0) chk({tag, "_sat"}, 32'(sat), 32'(e.sat));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [1:0] m);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_ci = ci;
        in_mode = m;
    endtask

    task automatic one(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [1:0] m);
        res_t e;
        logic s8, s1;
        e = model(a, b, ci, m);
        s8 = 1'b0;
        s1 = 1'b0;
        drive(a, b, ci, m);
        tick();
        in_valid = 1'b0;
`ifdef PIPE_ADD_SAT_EN
        s1 = sat1;
`endif
        chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_s1_valid"}, 32'(out_valid1), 32'd1);
        chk_res({tag, "_s1"}, out_sum1, out_co1, s1, e);
        tick();
`ifdef PIPE_ADD_SAT_EN
        s8 = sat8;
`endif
        chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
        chk_res(tag, out_sum, out_co, s8, e);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa[16], sb[16];
        logic       sci[16];
        logic [1:0] sm[16];
        logic [8:0] held;
        logic       s8;
        int         sent, rcv;
        res_t       e;
        held = '0;
        s8 = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_co", 32'(out_co), 32'd0);
`ifdef PIPE_ADD_SAT_EN
        chk("rst_sat", 32'(sat8), 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        one("add_ff_01", 8'hFF, 8'h01, 1'b0, 2'd0);
        one("sub_10_20", 8'h10, 8'h20, 1'b0, 2'd1);
        one("inc_7f", 8'h7F, 8'h00, 1'b0, 2'd2);
        one("add_0f_01", 8'h0F, 8'h01, 1'b0, 2'd0);
        one("pass_a5", 8'hA5, 8'hFF, 1'b1, 2'd3);
        one("add_ci", 8'h3C, 8'h4D, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++)
            one("rand", 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));

        a16 = 16'h0FFF;
        b16 = 16'h0001;
        v16 = 1'b1;
        tick();
        v16 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("w16_lat_valid", 32'(out_valid16), 32'd0);
            tick();
        end
        chk("w16_valid", 32'(out_valid16), 32'd1);
        chk("w16_sum", 32'(sum16), 32'h1000);
        chk("w16_co", 32'(out_co16), 32'd0);
        a16 = 16'hFFFF;
        v16 = 1'b1;
        tick();
        v16 = 1'b0;
        tick();
        tick();
        tick();
        chk("w16_wrap_valid", 32'(out_valid16), 32'd1);
`ifdef PIPE_ADD_SAT_EN
        chk("w16_wrap_sum", 32'(sum16), 32'hFFFF);
        chk("w16_wrap_sat", 32'(sat16), 32'd1);
`else
        chk("w16_wrap_sum", 32'(sum16), 32'h0000);
`endif
        chk("w16_wrap_co", 32'(out_co16), 32'd1);
        tick();

        for (int i = 0; i < 16; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
            sci[i] = 1'($urandom);
            sm[i] = 2'($urandom_range(0, 3));
        end
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 60 && rcv < 16; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid = (sent < 16);
            if (sent < 16) drive(sa[sent], sb[sent], sci[sent], sm[sent]);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'(!(c >= 5 && c <= 7)));
            if (c == 5) held = {out_co, out_sum};
            if (c == 6 || c == 7) chk("stall_hold", 32'({out_co, out_sum}), 32'(held));
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sa[sent], sb[sent], sci[sent], sm[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("stream_expected_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
`ifdef PIPE_ADD_SAT_EN
                    s8 = sat8;
`endif
                    chk_res("stream", out_sum, out_co, s8, e);
                end
                rcv++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 32'(sent), 32'd16);
        chk("stream_rcv", 32'(rcv), 32'd16);
        for (int i = 0; i < 3; i++) begin
            chk("stream_no_dup", 32'(out_valid), 32'd0);
            tick();
        end

        drive(8'h12, 8'h34, 1'b0, 2'd0);
        tick();
        drive(8'h56, 8'h78, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(out_sum), 32'd0);
        chk("midrst_co", 32'(out_co), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
